// File: rtl/dma_pkg.sv
// Shared AXI encodings, burst geometry and FSM states for the DMA write-side engine.
package dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    localparam int BURST_BEATS = 256;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } wr_state_e;

    // AWSIZE encoding for a bus of the given width in bits.
    function automatic logic [2:0] axi_size(input int width);
        case (width)
            8:       axi_size = 3'd0;
            16:      axi_size = 3'd1;
            32:      axi_size = 3'd2;
            64:      axi_size = 3'd3;
            128:     axi_size = 3'd4;
            256:     axi_size = 3'd5;
            512:     axi_size = 3'd6;
            1024:    axi_size = 3'd7;
            default: axi_size = 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/send_wr_data.sv
// W-channel beat sequencer: gates the data stream onto W once the matching AW
// has been issued, counts beats within a burst and produces WLAST.
module send_wr_data
    import dma_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       run,
    input  logic [8:0] aw_cnt,
    input  logic [8:0] nb,
    input  logic [7:0] last_len,
    input  logic       s_valid,
    input  logic       wready,
    output logic       wvalid,
    output logic       s_ready,
    output logic       wlast,
    output logic [8:0] w_cnt
);

    logic [7:0] beat_cnt;
    logic [7:0] cur_len;
    logic       w_en;
    logic       w_hs;

    // Only the final burst is short; every earlier burst is a full 256 beats.
    assign w_en    = run && (w_cnt < aw_cnt);
    assign cur_len = (w_cnt == nb - 9'd1) ? last_len : 8'(BURST_BEATS - 1);
    assign wvalid  = s_valid & w_en;
    assign s_ready = wready & w_en;
    assign wlast   = w_en && (beat_cnt == cur_len);
    assign w_hs    = wvalid && wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= 8'd0;
            w_cnt    <= 9'd0;
        end else if (clear) begin
            beat_cnt <= 8'd0;
            w_cnt    <= 9'd0;
        end else if (w_hs) begin
            if (wlast) begin
                beat_cnt <= 8'd0;
                w_cnt    <= w_cnt + 9'd1;
            end else begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/send_wr_cmd_data.sv
// DMA write-side AXI master: splits a transfer into INCR bursts on AW, streams W,
// collects B. Define DMA_WR_BRESP_CHK_EN to flag SLVERR/DECERR responses on err.
module send_wr_cmd_data
    import dma_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [C_AXI_DATA_WIDTH-1:0]   dst_addr,
    input  logic [15:0]                   size,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    input  logic [C_AXI_DATA_WIDTH-1:0]   s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                    M_AXI_AWLEN,
    output logic [2:0]                    M_AXI_AWSIZE,
    output logic [1:0]                    M_AXI_AWBURST,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                          M_AXI_WLAST,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    localparam int         W          = C_AXI_DATA_WIDTH;
    localparam int         ADDR_SHIFT = int'(axi_size(W)) + 8;
    localparam logic [8:0] MAX_OUT    = 9'(MAX_OUTSTANDING);

    wr_state_e       state, next_state;
    logic [W-1:0]    dst_r;
    logic [15:0]     size_r;
    logic [8:0]      aw_cnt, b_cnt, w_cnt, nb;
    logic            run, accept, aw_valid, aw_hs, b_hs, last_b;

    assign nb     = {1'b0, size_r[15:8]} + 9'd1;
    assign run    = (state == ST_RUN);
    assign accept = start && (state == ST_IDLE);
    assign busy   = run;

    // AWVALID only drops on its own handshake: b_cnt can only shrink the outstanding count.
    assign aw_valid = run && (aw_cnt < nb) && ((aw_cnt - b_cnt) < MAX_OUT);
    assign aw_hs    = aw_valid && M_AXI_AWREADY;
    assign b_hs     = run && M_AXI_BVALID;
    assign last_b   = b_hs && ((b_cnt + 9'd1) == nb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            ST_IDLE: if (start) next_state = ST_RUN;
            ST_RUN: begin
                if (last_b) begin
                    next_state = ST_IDLE;
                    done       = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_r  <= '0;
            size_r <= 16'd0;
            aw_cnt <= 9'd0;
            b_cnt  <= 9'd0;
        end else if (accept) begin
            dst_r  <= dst_addr;
            size_r <= size;
            aw_cnt <= 9'd0;
            b_cnt  <= 9'd0;
        end else begin
            if (aw_hs) aw_cnt <= aw_cnt + 9'd1;
            if (b_hs)  b_cnt  <= b_cnt + 9'd1;
        end
    end

    assign M_AXI_AWVALID = aw_valid;
    assign M_AXI_AWADDR  = aw_valid ? dst_r + (W'(aw_cnt) << ADDR_SHIFT) : '0;
    assign M_AXI_AWLEN   = aw_valid ? ((aw_cnt == nb - 9'd1) ? size_r[7:0] : 8'hFF) : 8'h00;
    assign M_AXI_AWSIZE  = run ? axi_size(W) : 3'd0;
    assign M_AXI_AWBURST = run ? AXI_BURST_INCR : 2'b00;
    assign M_AXI_WDATA   = run ? s_data : '0;
    assign M_AXI_WSTRB   = {(W/8){run}};
    assign M_AXI_BREADY  = run;

    send_wr_data u_wr_data (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .run      (run),
        .aw_cnt   (aw_cnt),
        .nb       (nb),
        .last_len (size_r[7:0]),
        .s_valid  (s_valid),
        .wready   (M_AXI_WREADY),
        .wvalid   (M_AXI_WVALID),
        .s_ready  (s_ready),
        .wlast    (M_AXI_WLAST),
        .w_cnt    (w_cnt)
    );

`ifdef DMA_WR_BRESP_CHK_EN
    logic err_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_r <= 1'b0;
        else if (accept)
            err_r <= 1'b0;
        else if (b_hs && (M_AXI_BRESP == BRESP_SLVERR || M_AXI_BRESP == BRESP_DECERR))
            err_r <= 1'b1;
    end

    assign err = err_r;
`else
    logic unused_bresp;
    assign unused_bresp = ^M_AXI_BRESP;
    assign err          = 1'b0;
`endif

endmodule
